frame_draw_sequencer: RTL and testbench



---
 rtl/frame_draw_sequencer_pkg.sv | 83 ++++++++
 rtl/frame_draw_sequencer_frame_tick_gen.sv | 34 +++
 rtl/frame_draw_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_frame_draw_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_draw_sequencer_pkg.sv
// Shared types and constants for the frame draw sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, client index constants, screen geometry,
// the registered pixel bundle, and small helpers for client selection.
package frame_draw_sequencer_pkg;

    // FSM state encoding. ST_CLEAR is only reachable when FRAME_CLEAR_EN is
    // defined; its code stays reserved so the encoding does not shift.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_GRANT   = 3'd2,
        ST_RUN     = 3'd3,
        ST_RELEASE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Client indices, in grant order
    localparam logic [1:0] CLIENT_CATCHER = 2'd0;
    localparam logic [1:0] CLIENT_SQUARES = 2'd1;
    localparam logic [1:0] CLIENT_SCORE   = 2'd2;

    // Screen geometry
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    // Per-client plot field widths
    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int C_W = 3;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [C_W-1:0] color;
    } pixel_t;

    // Pull client idx's x/y/color out of the flattened client buses.
    // An index past the last client yields a blank pixel.
    function automatic pixel_t client_pixel(
        input logic [23:0] xs,
        input logic [20:0] ys,
        input logic [8:0]  cs,
        input logic [1:0]  idx
    );
        pixel_t p;
        p = '0;
        case (idx)
            CLIENT_CATCHER: begin
                p.x     = xs[7:0];
                p.y     = ys[6:0];
                p.color = cs[2:0];
            end
            CLIENT_SQUARES: begin
                p.x     = xs[15:8];
                p.y     = ys[13:7];
                p.color = cs[5:3];
            end
            CLIENT_SCORE: begin
                p.x     = xs[23:16];
                p.y     = ys[20:14];
                p.color = cs[8:6];
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    // One-hot draw mask for a client index; zero for out-of-range indices.
    function automatic logic [2:0] grant_mask(input logic [1:0] idx);
        logic [2:0] m;
        case (idx)
            CLIENT_CATCHER: m = 3'b001;
            CLIENT_SQUARES: m = 3'b010;
            CLIENT_SCORE:   m = 3'b100;
            default:        m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/frame_draw_sequencer_frame_tick_gen.sv
// Free-running frame divider producing a one-cycle frame tick.
// Latency: tick is registered; first pulse FRAME_DIV cycles after reset release.
// Backpressure: none; the tick is emitted regardless of downstream state.
//
// Ports:
//   clock      in   system clock
//   reset      in   asynchronous active-low reset
//   frame_tick out  one-cycle pulse each time the divider wraps
module frame_tick_gen #(
    parameter int FRAME_DIV = 833333
) (
    input  logic clock,
    input  logic reset,
    output logic frame_tick
);

    localparam int CNT_W = $clog2(FRAME_DIV);

    logic [CNT_W-1:0] div_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt    <= '0;
            frame_tick <= 1'b0;
        end else if (div_cnt == CNT_W'(FRAME_DIV - 1)) begin
            div_cnt    <= '0;
            frame_tick <= 1'b1;
        end else begin
            div_cnt    <= div_cnt + CNT_W'(1);
            frame_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/frame_draw_sequencer.sv
// Frame sequencer: arbitrates the single VGA plot port among drawer clients.
// Latency: plot outputs are registered, one cycle behind the granted client.
// Backpressure: none toward VGA; clients are held off by draw low and abandoned on timeout.
//
// Ports:
//   clock, reset           system clock, asynchronous active-low reset
//   client_en[2:0]         per-client enable, sampled when that client's turn comes up
//   client_finish[2:0]     finish_drawing from each client (only the granted one counts)
//   client_x/y/color       flattened per-client plot fields (8/7/3 bits per client)
//   client_draw[2:0]       one-hot draw grant
//   vga_x/y/color, vga_plot registered plot port toward the VGA adapter
//   frame_tick             one-cycle frame boundary pulse
//   busy                   frame in progress
//   frame_count            completed frames (wraps)
//   timeout_err[2:0]       sticky per-client timeout flags
//   overrun                sticky: a tick arrived while a frame was still running
//
// Build option: FRAME_CLEAR_EN adds a full-screen clear sweep (colour 0)
// at the start of each frame, before the first client is granted.
module frame_draw_sequencer
    import frame_draw_sequencer_pkg::*;
#(
    parameter int FRAME_DIV      = 833333,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int NUM_CLIENTS    = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  client_en,
    input  logic [2:0]  client_finish,
    input  logic [23:0] client_x,
    input  logic [20:0] client_y,
    input  logic [8:0]  client_color,
    output logic [2:0]  client_draw,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_color,
    output logic        vga_plot,
    output logic        frame_tick,
    output logic        busy,
    output logic [15:0] frame_count,
    output logic [2:0]  timeout_err,
    output logic        overrun
);

    localparam int         TCNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] LAST_IDX = 2'(NUM_CLIENTS - 1);

    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
    logic [2:0]         draw_q, draw_d;
    pixel_t             pix_q, pix_d;
    logic               plot_q, plot_d;
    logic               busy_q, busy_d;
    logic [15:0]        fc_q, fc_d;
    logic [2:0]         terr_q, terr_d;
    logic               ovr_q, ovr_d;
    pixel_t             sel_pix;
    logic [3:0]         en_ext;
    logic [3:0]         fin_ext;

`ifdef FRAME_CLEAR_EN
    logic [7:0]         cx_q, cx_d;
    logic [6:0]         cy_q, cy_d;
`endif

    frame_tick_gen #(
        .FRAME_DIV (FRAME_DIV)
    ) u_tick (
        .clock      (clock),
        .reset      (reset),
        .frame_tick (frame_tick)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tcnt_d  = tcnt_q;
        draw_d  = draw_q;
        pix_d   = pix_q;
        plot_d  = 1'b0;
        busy_d  = busy_q;
        fc_d    = fc_q;
        terr_d  = terr_q;
        // A tick that lands while a frame is still running is dropped.
        ovr_d   = ovr_q | (frame_tick & busy_q);
`ifdef FRAME_CLEAR_EN
        cx_d    = cx_q;
        cy_d    = cy_q;
`endif
        sel_pix = client_pixel(client_x, client_y, client_color, idx_q);
        // Zero-extended so idx_q == 3 reads as disabled / not finished.
        en_ext  = {1'b0, client_en};
        fin_ext = {1'b0, client_finish};

        case (state_q)
            ST_IDLE: begin
                if (frame_tick) begin
                    busy_d = 1'b1;
                    idx_d  = CLIENT_CATCHER;
`ifdef FRAME_CLEAR_EN
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = ST_CLEAR;
`else
                    state_d = ST_GRANT;
`endif
                end
            end

`ifdef FRAME_CLEAR_EN
            ST_CLEAR: begin
                plot_d      = 1'b1;
                pix_d.x     = cx_q;
                pix_d.y     = cy_q;
                pix_d.color = '0;
                if (cx_q == 8'(SCREEN_W - 1)) begin
                    cx_d = '0;
                    if (cy_q == 7'(SCREEN_H - 1)) begin
                        cy_d    = '0;
                        state_d = ST_GRANT;
                    end else begin
                        cy_d = cy_q + 7'd1;
                    end
                end else begin
                    cx_d = cx_q + 8'd1;
                end
            end
`endif

            ST_GRANT: begin
                if (idx_q > LAST_IDX) begin
                    state_d = ST_DONE;
                end else if (!en_ext[idx_q]) begin
                    // Skipping the last client goes straight to DONE rather
                    // than spending a cycle on an out-of-range index.
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    draw_d  = grant_mask(idx_q);
                    tcnt_d  = '0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (fin_ext[idx_q]) begin
                    // Drop draw on the same edge so the client rewinds its
                    // scan instead of starting another pass.
                    draw_d  = '0;
                    state_d = ST_RELEASE;
                end else begin
                    // tcnt_q == 0 marks the first RUN cycle; the client's
                    // registered outputs are not valid yet.
                    if (tcnt_q != '0) begin
                        plot_d = 1'b1;
                        pix_d  = sel_pix;
                    end
                    if (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
                        terr_d  = terr_q | grant_mask(idx_q);
                        draw_d  = '0;
                        state_d = ST_RELEASE;
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end
            end

            ST_RELEASE: begin
                idx_d   = idx_q + 2'd1;
                state_d = ST_GRANT;
            end

            ST_DONE: begin
                fc_d    = fc_q + 16'd1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            tcnt_q  <= '0;
            draw_q  <= '0;
            pix_q   <= '0;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            fc_q    <= '0;
            terr_q  <= '0;
            ovr_q   <= 1'b0;
`ifdef FRAME_CLEAR_EN
            cx_q    <= '0;
            cy_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tcnt_q  <= tcnt_d;
            draw_q  <= draw_d;
            pix_q   <= pix_d;
            plot_q  <= plot_d;
            busy_q  <= busy_d;
            fc_q    <= fc_d;
            terr_q  <= terr_d;
            ovr_q   <= ovr_d;
`ifdef FRAME_CLEAR_EN
            cx_q    <= cx_d;
            cy_q    <= cy_d;
`endif
        end
    end

    assign client_draw = draw_q;
    assign vga_x       = pix_q.x;
    assign vga_y       = pix_q.y;
    assign vga_color   = pix_q.color;
    assign vga_plot    = plot_q;
    assign busy        = busy_q;
    assign frame_count = fc_q;
    assign timeout_err = terr_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_frame_draw_sequencer.sv
// Testbench for frame_draw_sequencer.
// Latency: n/a.
// Backpressure: n/a.
//
// An expected timeline for each run is built from the frame rules (tick
// schedule, per-client grant lengths, pixel latency) and compared cycle by
// cycle at the falling edge; directed scenarios also carry hand-derived
// end-of-run values.
module tb_frame_draw_sequencer;

    localparam int FD   = 16;
    localparam int TO   = 20;
    localparam int MAXC = 400;
    localparam int NEVER = 99;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  client_en = '0;
    logic [2:0]  client_finish = '0;
    logic [23:0] client_x = '0;
    logic [20:0] client_y = '0;
    logic [8:0]  client_color = '0;
    logic [2:0]  client_draw;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_color;
    logic        vga_plot;
    logic        frame_tick;
    logic        busy;
    logic [15:0] frame_count;
    logic [2:0]  timeout_err;
    logic        overrun;

    always #5 clock = ~clock;

    frame_draw_sequencer #(
        .FRAME_DIV      (FD),
        .TIMEOUT_CYCLES (TO),
        .NUM_CLIENTS    (3)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .client_en     (client_en),
        .client_finish (client_finish),
        .client_x      (client_x),
        .client_y      (client_y),
        .client_color  (client_color),
        .client_draw   (client_draw),
        .vga_x         (vga_x),
        .vga_y         (vga_y),
        .vga_color     (vga_color),
        .vga_plot      (vga_plot),
        .frame_tick    (frame_tick),
        .busy          (busy),
        .frame_count   (frame_count),
        .timeout_err   (timeout_err),
        .overrun       (overrun)
    );

    int checks = 0;
    int errors = 0;

    // Stimulus per cycle (applied during cycle c, sampled on edge c+1)
    logic [2:0]  in_fin [MAXC];
    logic [23:0] in_x   [MAXC];
    logic [20:0] in_y   [MAXC];
    logic [8:0]  in_c   [MAXC];
    // Expected outputs per cycle (visible after edge c)
    logic [2:0]  e_draw [MAXC];
    logic        e_plot [MAXC];
    logic [17:0] e_pix  [MAXC];
    logic        e_tick [MAXC];
    logic        e_busy [MAXC];
    logic        e_fcinc[MAXC];
    logic [2:0]  e_teat [MAXC];
    logic        e_ovat [MAXC];
    logic [20:0] e_stat [MAXC];

    typedef struct {
        logic [2:0]  en;
        int          f0, f1, f2;
        int          ncyc;
        int          abort_at;
        logic [15:0] fc;
        logic [2:0]  te;
        logic        ov;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Build the expected timeline. fin = RUN cycle index on which the client
    // raises finish (0 = first RUN cycle); fin >= TO means it never finishes.
    task automatic plan(input int ncyc, input logic [2:0] en,
                        input int f0, input int f1, input int f2, input bit rnd);
        int fin[3];
        int done, cur, len, c;
        logic [15:0] fc;
        logic [2:0]  te;
        logic        ov;
        for (int i = 0; i < ncyc; i++) begin
            in_x[i]    = 24'($urandom);
            in_y[i]    = 21'($urandom);
            in_c[i]    = 9'($urandom);
            in_fin[i]  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            e_draw[i]  = '0;
            e_plot[i]  = 1'b0;
            e_pix[i]   = '0;
            e_tick[i]  = 1'b0;
            e_busy[i]  = 1'b0;
            e_fcinc[i] = 1'b0;
            e_teat[i]  = '0;
            e_ovat[i]  = 1'b0;
        end
        done = -1;
        for (int n = FD; n < ncyc; n += FD) begin
            e_tick[n] = 1'b1;
            if (n <= done) begin
                if (n + 1 < ncyc) e_ovat[n+1] = 1'b1;
            end else begin
                if (rnd) begin
                    for (int k = 0; k < 3; k++) fin[k] = $urandom_range(0, 24);
                end else begin
                    fin = '{f0, f1, f2};
                end
                cur = n + 1;                       // first GRANT cycle
                for (int k = 0; k < 3; k++) begin
                    if (!en[k]) begin
                        if (k < 2) cur++;
                    end else begin
                        len = (fin[k] < TO) ? fin[k] + 1 : TO;
                        for (int r = 0; r < len; r++) begin
                            c = cur + 1 + r;
                            if (c < ncyc) begin
                                e_draw[c][k] = 1'b1;
                                in_fin[c][k] = (r == fin[k]);
                            end
                            if (r >= 1 && r != fin[k] && c + 1 < ncyc) begin
                                e_plot[c+1] = 1'b1;
                                e_pix[c+1]  = {in_x[c][8*k +: 8], in_y[c][7*k +: 7], in_c[c][3*k +: 3]};
                            end
                        end
                        if (fin[k] >= TO && cur + len + 1 < ncyc) e_teat[cur+len+1][k] = 1'b1;
                        cur += len + 2;             // RUN cycles + RELEASE
                    end
                end
                done = cur + 1;
                for (c = n + 1; c <= done && c < ncyc; c++) e_busy[c] = 1'b1;
                if (done + 1 < ncyc) e_fcinc[done+1] = 1'b1;
            end
        end
        fc = '0; te = '0; ov = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            fc = fc + 16'(e_fcinc[i]);
            te = te | e_teat[i];
            ov = ov | e_ovat[i];
            e_stat[i] = {e_busy[i], fc, te, ov};
        end
    endtask

    task automatic run_phase(input int ncyc, input logic [2:0] en, input int abort_at);
        reset = 1'b0;
        client_en = en;
        client_finish = '0;
        repeat (2) @(negedge clock);
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) @(negedge clock);
            check("draw", client_draw, e_draw[c]);
            check("plot", vga_plot, e_plot[c]);
            if (e_plot[c] || c == 0) check("pixel", {vga_x, vga_y, vga_color}, e_pix[c]);
            check("tick", frame_tick, e_tick[c]);
            check("status", {busy, frame_count, timeout_err, overrun}, e_stat[c]);
            if (c == abort_at) begin
                reset = 1'b0;
                #1;
                check("async_reset", {client_draw, vga_x, vga_y, vga_color, vga_plot,
                                      frame_tick, busy, frame_count, timeout_err, overrun}, 64'd0);
                return;
            end
            if (c == 0) reset = 1'b1;
            client_finish = in_fin[c];
            client_x      = in_x[c];
            client_y      = in_y[c];
            client_color  = in_c[c];
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

`ifdef FRAME_CLEAR_EN
    initial begin
        int cnt;
        bit seen;
        cnt = 0;
        seen = 1'b0;
        client_en = 3'b001;
        client_finish = 3'b001;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 20000 && !seen; i++) begin
            @(negedge clock);
            if (client_draw[0]) begin
                seen = 1'b1;
            end else if (vga_plot) begin
                check("clear_pixel", {vga_x, vga_y, vga_color},
                      {8'(cnt % 160), 7'(cnt / 160), 3'b000});
                cnt++;
            end
        end
        check("clear_count", cnt, 19200);
        check("clear_then_grant", seen, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
`else
    initial begin
        vec_t vecs[7];
        logic [2:0] en;
        vecs[0] = '{en: 3'b111, f0: 6,  f1: 6,     f2: 6, ncyc: 47, abort_at: -1, fc: 16'd1, te: 3'b000, ov: 1'b1};
        vecs[1] = '{en: 3'b111, f0: 3,  f1: NEVER, f2: 2, ncyc: 60, abort_at: -1, fc: 16'd1, te: 3'b010, ov: 1'b1};
        vecs[2] = '{en: 3'b000, f0: 0,  f1: 0,     f2: 0, ncyc: 70, abort_at: -1, fc: 16'd4, te: 3'b000, ov: 1'b0};
        vecs[3] = '{en: 3'b001, f0: 15, f1: 0,     f2: 0, ncyc: 70, abort_at: -1, fc: 16'd1, te: 3'b000, ov: 1'b1};
        vecs[4] = '{en: 3'b101, f0: 0,  f1: 0,     f2: 1, ncyc: 40, abort_at: -1, fc: 16'd1, te: 3'b000, ov: 1'b0};
        vecs[5] = '{en: 3'b111, f0: 6,  f1: 6,     f2: 6, ncyc: 47, abort_at: 38, fc: 16'd0, te: 3'b000, ov: 1'b0};
        vecs[6] = '{en: 3'b111, f0: 6,  f1: 6,     f2: 6, ncyc: 47, abort_at: -1, fc: 16'd1, te: 3'b000, ov: 1'b1};

        for (int v = 0; v < 7; v++) begin
            plan(vecs[v].ncyc, vecs[v].en, vecs[v].f0, vecs[v].f1, vecs[v].f2, 1'b0);
            run_phase(vecs[v].ncyc, vecs[v].en, vecs[v].abort_at);
            if (vecs[v].abort_at < 0) begin
                check("final_frame_count", frame_count, vecs[v].fc);
                check("final_timeout_err", timeout_err, vecs[v].te);
                check("final_overrun", overrun, vecs[v].ov);
            end
        end

        for (int p = 0; p < 8; p++) begin
            en = 3'($urandom);
            plan(300, en, 0, 0, 0, 1'b1);
            run_phase(300, en, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
`endif

endmodule
